// File: rtl/letc_core_pkg.sv
// Shared types for the LETC core data-memory port: access size, port FSM state, latched request.
package letc_core_pkg;

    localparam int DMSS_DATA_W = 32;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } dmss_size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } dmss_state_e;

    // The word address lives beside this struct in the port so the struct stays width-independent.
    typedef struct packed {
        logic                   we;
        dmss_size_e             size;
        logic                   is_unsigned;
        logic [1:0]             addr_lo;
        logic [DMSS_DATA_W-1:0] wdata;
    } dmss_req_s;

    // The reserved encoding 3 behaves as a word access.
    function automatic dmss_size_e dmss_size_decode(input logic [1:0] raw);
        dmss_size_e s;
        case (raw)
            2'd0:    s = SIZE_BYTE;
            2'd1:    s = SIZE_HALF;
            default: s = SIZE_WORD;
        endcase
        return s;
    endfunction

    function automatic logic dmss_misaligned(input dmss_size_e size, input logic [1:0] addr_lo);
        logic m;
        case (size)
            SIZE_HALF: m = addr_lo[0];
            SIZE_WORD: m = |addr_lo;
            default:   m = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/letc_core_dmss_lane.sv
// Byte-lane steering: store strobe/replication and load shift plus sign/zero extension.
// Latency: purely combinational. Backpressure: none, no state.
// Word accesses ignore the low address bits, so misaligned words see the aligned word.
module letc_core_dmss_lane
    import letc_core_pkg::*;
(
    input  dmss_size_e              size,
    input  logic [1:0]              addr_lo,
    input  logic                    is_unsigned,
    input  logic [DMSS_DATA_W-1:0]  wdata,
    input  logic [DMSS_DATA_W-1:0]  rdata,
    output logic [3:0]              wstrb,
    output logic [DMSS_DATA_W-1:0]  wdata_rep,
    output logic [DMSS_DATA_W-1:0]  load_data
);

    logic [DMSS_DATA_W-1:0] shifted;

    always_comb begin
        shifted   = rdata >> {addr_lo, 3'b000};
        wstrb     = 4'hF;
        wdata_rep = wdata;
        load_data = rdata;
        case (size)
            SIZE_BYTE: begin
                wstrb     = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                load_data = {{24{shifted[7] & ~is_unsigned}}, shifted[7:0]};
            end
            SIZE_HALF: begin
                wstrb     = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_rep = {2{wdata[15:0]}};
                load_data = {{16{shifted[15] & ~is_unsigned}}, shifted[15:0]};
            end
            default: begin
                wstrb     = 4'hF;
                wdata_rep = wdata;
                load_data = rdata;
            end
        endcase
    end

endmodule

// File: rtl/letc_core_dmss_port.sv
// Memory1/memory2 data port driving a single-outstanding data bus; LETC_DMSS_MISALIGN_CHECK_EN adds misalign faulting.
// Latency: accept at edge N, response valid in cycle N+3 when the bus answers the cycle after accepting.
// Backpressure: m1_req_ready only in IDLE/DONE; dmss_stall holds memory2 while REQ or WAIT.
module letc_core_dmss_port
    import letc_core_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m1_req_valid,
    output logic              m1_req_ready,
    input  logic              m1_req_we,
    input  logic [1:0]        m1_req_size,
    input  logic              m1_req_unsigned,
    input  logic [ADDR_W-1:0] m1_req_addr,
    input  logic [31:0]       m1_req_wdata,
    input  logic              m2_flush,
    output logic              dmss_stall,
    output logic              m2_rsp_valid,
    output logic [31:0]       m2_rsp_load_data,
    output logic              m2_rsp_fault,
`ifdef LETC_DMSS_MISALIGN_CHECK_EN
    output logic              m2_rsp_misaligned,
`endif
    output logic              bus_req_valid,
    input  logic              bus_req_ready,
    output logic [ADDR_W-1:0] bus_req_addr,
    output logic              bus_req_we,
    output logic [3:0]        bus_req_wstrb,
    output logic [31:0]       bus_req_wdata,
    input  logic              bus_rsp_valid,
    input  logic [31:0]       bus_rsp_rdata,
    input  logic              bus_rsp_err
);

    localparam bit         TMO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    dmss_state_e        state_q;
    dmss_req_s          req_q;
    dmss_req_s          req_in;
    logic [ADDR_W-1:2]  word_addr_q;
    logic [31:0]        rsp_data_q;
    logic               rsp_fault_q;
    logic               discard_q;
    logic               live_q;
    logic [7:0]         tmo_cnt_q;
    logic               accept;
    logic               tmo_hit;
    logic [3:0]         lane_wstrb;
    logic [31:0]        lane_wdata;
    logic [31:0]        lane_load;
`ifdef LETC_DMSS_MISALIGN_CHECK_EN
    logic               mis_q;
    logic               mis_in;
`endif

    always_comb begin
        req_in             = '0;
        req_in.we          = m1_req_we;
        req_in.size        = dmss_size_decode(m1_req_size);
        req_in.is_unsigned = m1_req_unsigned;
        req_in.addr_lo     = m1_req_addr[1:0];
        req_in.wdata       = m1_req_wdata;
    end

`ifdef LETC_DMSS_MISALIGN_CHECK_EN
    assign mis_in = dmss_misaligned(req_in.size, req_in.addr_lo);
`endif

    assign m1_req_ready = live_q && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign accept       = m1_req_valid && m1_req_ready;
    assign tmo_hit      = TMO_EN && (tmo_cnt_q == TMO_LAST);

    letc_core_dmss_lane u_lane (
        .size        (req_q.size),
        .addr_lo     (req_q.addr_lo),
        .is_unsigned (req_q.is_unsigned),
        .wdata       (req_q.wdata),
        .rdata       (bus_rsp_rdata),
        .wstrb       (lane_wstrb),
        .wdata_rep   (lane_wdata),
        .load_data   (lane_load)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            req_q       <= '0;
            word_addr_q <= '0;
            rsp_data_q  <= '0;
            rsp_fault_q <= 1'b0;
            discard_q   <= 1'b0;
            live_q      <= 1'b0;
            tmo_cnt_q   <= '0;
`ifdef LETC_DMSS_MISALIGN_CHECK_EN
            mis_q       <= 1'b0;
`endif
        end else begin
            live_q <= 1'b1;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        req_q       <= req_in;
                        word_addr_q <= m1_req_addr[ADDR_W-1:2];
                        discard_q   <= 1'b0;
                        rsp_data_q  <= '0;
`ifdef LETC_DMSS_MISALIGN_CHECK_EN
                        mis_q       <= mis_in;
                        rsp_fault_q <= mis_in;
                        state_q     <= mis_in ? ST_DONE : ST_REQ;
`else
                        rsp_fault_q <= 1'b0;
                        state_q     <= ST_REQ;
`endif
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    // A flush coinciding with acceptance still owes the bus a response, so drain it.
                    if (bus_req_ready) begin
                        state_q   <= ST_WAIT;
                        tmo_cnt_q <= '0;
                        discard_q <= m2_flush;
                    end else if (m2_flush) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    tmo_cnt_q <= tmo_cnt_q + 8'd1;
                    if (bus_rsp_valid || tmo_hit) begin
                        if (discard_q || m2_flush) begin
                            state_q <= ST_IDLE;
                        end else begin
                            state_q     <= ST_DONE;
                            rsp_fault_q <= bus_rsp_valid ? bus_rsp_err : 1'b1;
                            rsp_data_q  <= (bus_rsp_valid && !req_q.we) ? lane_load : '0;
                        end
                    end else if (m2_flush) begin
                        discard_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign dmss_stall       = (state_q == ST_REQ) || (state_q == ST_WAIT);
    assign m2_rsp_valid     = (state_q == ST_DONE) && !m2_flush;
    assign m2_rsp_load_data = m2_rsp_valid ? rsp_data_q : '0;
    assign m2_rsp_fault     = m2_rsp_valid && rsp_fault_q;
`ifdef LETC_DMSS_MISALIGN_CHECK_EN
    assign m2_rsp_misaligned = m2_rsp_valid && mis_q;
`endif

    assign bus_req_valid = (state_q == ST_REQ);
    assign bus_req_addr  = bus_req_valid ? {word_addr_q, 2'b00} : '0;
    assign bus_req_we    = bus_req_valid && req_q.we;
    assign bus_req_wstrb = bus_req_valid ? lane_wstrb : '0;
    assign bus_req_wdata = bus_req_valid ? lane_wdata : '0;

endmodule

// File: doc/letc_core_dmss_port.md
Name: letc_core_dmss_port

Overview:
- Data-memory-subsystem responder for the LETC core pipeline.
- Accepts load/store requests issued by the memory1 stage and drives a single-outstanding external data bus.
- Returns aligned, sign/zero-extended load data to the memory2 stage.
- Asserts a stall while a bus transaction is in flight so the memory2 stage holds its pipeline register.

Parameters:
- ADDR_W, 32, byte address width on request and bus sides.
- TIMEOUT_CYCLES, 255, bus cycles without a response before an access fault is raised (8-bit counter; 0 disables timeout).

Ports:
- clk  input  1  core clock.
- rst_n  input  1  reset; asynchronous assert, active-low.
- m1_req_valid  input  1  memory1 issues a request this cycle.
- m1_req_ready  output  1  port can accept (state IDLE, or DONE being consumed).
- m1_req_we  input  1  1 = store, 0 = load.
- m1_req_size  input  2  0 = byte, 1 = half, 2 = word; 3 is reserved.
- m1_req_unsigned  input  1  zero-extend loads when 1.
- m1_req_addr  input  ADDR_W  byte address.
- m1_req_wdata  input  32  store data, LSB-justified.
- m2_flush  input  1  discard any in-flight response.
- dmss_stall  output  1  hold memory2 (asserted in REQ and WAIT).
- m2_rsp_valid  output  1  response data valid this cycle.
- m2_rsp_load_data  output  32  extended load data.
- m2_rsp_fault  output  1  bus error or timeout on this response.
- bus_req_valid  output  1  bus request.
- bus_req_ready  input  1  bus accepts.
- bus_req_addr  output  ADDR_W  word-aligned address.
- bus_req_we  output  1  write.
- bus_req_wstrb  output  4  byte enables.
- bus_req_wdata  output  32  lane-replicated store data.
- bus_rsp_valid  input  1  bus response.
- bus_rsp_rdata  input  32  read word.
- bus_rsp_err  input  1  bus error.

Behaviour:
- Reset values: all outputs 0, state IDLE; m1_req_ready = 1 after reset deasserts.
- FSM states:
  - IDLE: on m1_req_valid, latch the request and go to REQ.
  - REQ: bus_req_valid = 1; on bus_req_ready go to WAIT.
  - WAIT: on bus_rsp_valid, capture data/err and go to DONE.
  - DONE: m2_rsp_valid = 1 for exactly one cycle; go to IDLE, or to REQ if a new m1_req_valid arrives in the same cycle (back-to-back).
- Timeout: if TIMEOUT_CYCLES != 0, a counter clears on entering WAIT and increments each WAIT cycle; reaching TIMEOUT_CYCLES forces DONE with fault = 1 and data = 0.
- Minimum latency: request accepted at edge N; response valid in cycle N+3 when the bus responds the cycle after it accepts the request.
- Alignment: bus_req_addr = addr with bits[1:0] cleared.
  - wstrb: byte = 1 << a[1:0]; half = 3 << {a[1],1'b0}; word = 4'hF.
  - wdata: byte replicated ×4; half replicated ×2.
- Load extraction: shift rdata right by 8×a[1:0]; sign-extend from bit 7 or 15 unless unsigned.
- Stores: complete with m2_rsp_valid = 1 and load_data = 0.
- Flush:
  - In REQ before acceptance: drop the request, go to IDLE, no bus traffic.
  - In WAIT: set a discard flag; the bus response is consumed silently (no m2_rsp_valid), then go to IDLE.
  - In DONE: suppress m2_rsp_valid.
- Simultaneous flush and bus_rsp_valid in WAIT: response discarded.
- Reserved size 3: treated as word.
- rst_n asserted mid-transaction: FSM to IDLE immediately; a late bus response arriving after reset is ignored (bus must be reset together).

Optional Feature:
- Macro: LETC_DMSS_MISALIGN_CHECK_EN.
- Defined: half with a[0] = 1, or word with a[1:0] != 0, skips REQ/WAIT, goes IDLE→DONE with m2_rsp_fault = 1 and an extra output m2_rsp_misaligned = 1; no bus request is issued.
- Undefined: the port is absent; misaligned accesses are truncated to the aligned word (low address bits ignored beyond lane selection; halfword at a[1:0] = 3 uses lanes 3 and 0 wrapped is not guaranteed, only the lane-3 byte is valid).

Decomposition:
- letc_core_pkg: dmss_size_e (BYTE/HALF/WORD), dmss_state_e, dmss_req_s struct (we, size, unsigned, addr, wdata).
- Sub-module letc_core_dmss_lane: purely combinational wstrb/wdata replication and load shift/extend. Keeps the FSM file small and is unit-testable alone.

Test Plan:
- Load byte, addr 0x1003, unsigned = 0, rdata 0x80FF_1234 -> load_data 0xFFFF_FF80, rsp_valid in cycle N+3.
- Store half, addr 0x2002, wdata 0x0000_ABCD -> wstrb 4'b1100, bus wdata 0xABCD_ABCD, bus addr 0x2000.
- Load word, bus_req_ready held low 5 cycles -> dmss_stall high throughout, single rsp_valid pulse, data 0xDEAD_BEEF passed unchanged.
- m2_flush in WAIT, bus returns 0x1234_5678 two cycles later -> no m2_rsp_valid; next request proceeds normally.
- TIMEOUT_CYCLES = 4, bus never responds -> fault = 1, data = 0 on cycle 4 of WAIT.
- With LETC_DMSS_MISALIGN_CHECK_EN: word load at 0x1001 -> bus_req_valid never asserted, fault = 1 and misaligned = 1 next cycle.
